// File: rtl/ascon_pack.sv
// Shared types and widths for the ASCON session arbiter: FSM states, bus widths
// and the two-client arbitration rule.
package ascon_pack;

  localparam int unsigned NumClients = 2;
  localparam int unsigned KeyW       = 128;
  localparam int unsigned NonceW     = 128;
  localparam int unsigned BlockW     = 64;
  localparam int unsigned TagW       = 128;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StRun,
    StDone,
    StAbort
  } state_e;

  // A lone requester wins outright; under contention the priority pointer decides.
  function automatic logic pick_owner(logic [NumClients-1:0] req, logic prio);
    if (req == 2'b11) begin
      return prio;
    end
    return req[1];
  endfunction

endpackage

// File: rtl/ascon_session_arbiter_if.sv
// Client-side and core-side buses of the arbiter. The arbiter uses the slave view;
// clients and the ASCON core model together form the master view.
interface ascon_session_arbiter_if;
  import ascon_pack::*;

  logic [NumClients-1:0]             req_i;
  logic [NumClients-1:0][KeyW-1:0]   key_i;
  logic [NumClients-1:0][NonceW-1:0] nonce_i;
  logic [NumClients-1:0][BlockW-1:0] data_i;
  logic [NumClients-1:0]             data_valid_i;
  logic [NumClients-1:0]             gnt_o;
  logic [NumClients-1:0]             done_o;
  logic [NumClients-1:0]             err_o;
  logic [BlockW-1:0]                 cipher_o;
  logic [NumClients-1:0]             cipher_valid_o;
  logic [TagW-1:0]                   tag_o;

  logic                              core_start_o;
  logic [KeyW-1:0]                   core_key_o;
  logic [NonceW-1:0]                 core_nonce_o;
  logic [BlockW-1:0]                 core_data_o;
  logic                              core_data_valid_o;
  logic [BlockW-1:0]                 core_cipher_i;
  logic                              core_cipher_valid_i;
  logic [TagW-1:0]                   core_tag_i;
  logic                              core_end_i;

  modport slave (
    input  req_i, key_i, nonce_i, data_i, data_valid_i,
    input  core_cipher_i, core_cipher_valid_i, core_tag_i, core_end_i,
    output gnt_o, done_o, err_o, cipher_o, cipher_valid_o, tag_o,
    output core_start_o, core_key_o, core_nonce_o, core_data_o, core_data_valid_o
  );

  modport master (
    output req_i, key_i, nonce_i, data_i, data_valid_i,
    output core_cipher_i, core_cipher_valid_i, core_tag_i, core_end_i,
    input  gnt_o, done_o, err_o, cipher_o, cipher_valid_o, tag_o,
    input  core_start_o, core_key_o, core_nonce_o, core_data_o, core_data_valid_o
  );

endinterface

// File: rtl/watchdog_cpt.sv
// Session watchdog: loaded with LoadValue, counts down while enabled, and flags the
// enabled cycle whose decrement reaches zero.
module watchdog_cpt #(
  parameter int unsigned LoadValue = 1023
) (
  input  logic clock_i,
  input  logic resetb_i,
  input  logic load_i,
  input  logic enable_i,
  output logic zero_o
);

  localparam int unsigned CntW = (LoadValue < 1) ? 1 : $clog2(LoadValue + 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clock_i or posedge resetb_i) begin
    if (resetb_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= CntW'(LoadValue);
    end else if (enable_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CntW'(1);
    end
  end

  // Raised on the last permitted enabled cycle so LoadValue cycles are allowed in total.
  assign zero_o = enable_i && (cnt_q <= CntW'(1));

endmodule

// File: rtl/ascon_session_arbiter.sv
// Two-client arbiter in front of a single ASCON core: grants one session at a time,
// forwards the owner's key/nonce/data and returns cipher blocks, tag and status.
module ascon_session_arbiter
  import ascon_pack::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input logic                    clock_i,
  input logic                    resetb_i,
  ascon_session_arbiter_if.slave bus
);

  state_e                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  prio_q, prio_d;
  logic [BlockW-1:0]     cipher_q;
  logic [NumClients-1:0] cipher_valid_q;
  logic [TagW-1:0]       tag_q;
  logic [NumClients-1:0] owner_oh;
  logic                  in_run;
  logic                  core_active;
  logic                  wd_zero;

  assign in_run      = (state_q == StRun);
  assign core_active = (state_q == StStart) || in_run;
  assign owner_oh    = (state_q != StIdle) ? (NumClients'(1) << owner_q) : '0;

  watchdog_cpt #(
    .LoadValue(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clock_i (clock_i),
    .resetb_i(resetb_i),
    .load_i  (state_q == StStart),
    .enable_i(in_run),
    .zero_o  (wd_zero)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    prio_d  = prio_q;
    unique case (state_q)
      StIdle: begin
        if (|bus.req_i) begin
          owner_d = pick_owner(bus.req_i, prio_q);
          state_d = StStart;
        end
      end
      StStart: state_d = StRun;
      StRun: begin
        // Completion wins over a simultaneous watchdog expiry.
        if (bus.core_end_i) begin
          state_d = StDone;
        end else if (wd_zero) begin
          state_d = StAbort;
        end
      end
      StDone, StAbort: begin
        prio_d  = ~owner_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock_i or posedge resetb_i) begin
    if (resetb_i) begin
      state_q        <= StIdle;
      owner_q        <= 1'b0;
      prio_q         <= 1'b0;
      cipher_q       <= '0;
      cipher_valid_q <= '0;
      tag_q          <= '0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      prio_q         <= prio_d;
      cipher_valid_q <= (in_run && bus.core_cipher_valid_i) ? owner_oh : '0;
      if (in_run && bus.core_cipher_valid_i) begin
        cipher_q <= bus.core_cipher_i;
      end
      if (in_run && bus.core_end_i) begin
        tag_q <= bus.core_tag_i;
      end
    end
  end

  assign bus.gnt_o          = owner_oh;
  assign bus.done_o         = (state_q == StDone) ? owner_oh : '0;
  assign bus.err_o          = (state_q == StAbort) ? owner_oh : '0;
  assign bus.cipher_o       = cipher_q;
  assign bus.cipher_valid_o = cipher_valid_q;
  assign bus.tag_o          = tag_q;

  assign bus.core_start_o      = (state_q == StStart);
  assign bus.core_key_o        = core_active ? bus.key_i[owner_q] : '0;
  assign bus.core_nonce_o      = core_active ? bus.nonce_i[owner_q] : '0;
  assign bus.core_data_o       = in_run ? bus.data_i[owner_q] : '0;
  assign bus.core_data_valid_o = in_run && bus.data_valid_i[owner_q];

endmodule

// File: tb/tb_ascon_session_arbiter.sv
// Session-level bench: drives clients and a core model, predicting every output from
// the session timeline (grant, start, RUN beats, done/abort, idle).
module tb_ascon_session_arbiter;
  import ascon_pack::*;

  localparam int unsigned T = 8;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;
  int   prio;
  logic [127:0] tag_exp;

  ascon_session_arbiter_if bus ();

  ascon_session_arbiter #(
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clock_i (clk),
    .resetb_i(rst),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_pick(logic [1:0] req, int p);
    if (req == 2'b11) return p;
    return req[1] ? 1 : 0;
  endfunction

  task automatic clear_inputs();
    bus.req_i               = '0;
    bus.data_valid_i        = '0;
    bus.core_cipher_valid_i = 1'b0;
    bus.core_end_i          = 1'b0;
    bus.core_cipher_i       = '0;
    bus.core_tag_i          = '0;
    for (int c = 0; c < 2; c++) begin
      bus.key_i[c]   = '0;
      bus.nonce_i[c] = '0;
      bus.data_i[c]  = '0;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_gnt"}, bus.gnt_o, '0);
    check_eq({tag, "_done"}, bus.done_o, '0);
    check_eq({tag, "_err"}, bus.err_o, '0);
    check_eq({tag, "_cv"}, bus.cipher_valid_o, '0);
    check_eq({tag, "_cipher"}, bus.cipher_o, '0);
    check_eq({tag, "_tag"}, bus.tag_o, '0);
    check_eq({tag, "_start"}, bus.core_start_o, 1'b0);
    check_eq({tag, "_cdv"}, bus.core_data_valid_o, 1'b0);
    check_eq({tag, "_ckey"}, bus.core_key_o, '0);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    clear_inputs();
    #2;
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rst     = 1'b0;
    prio    = 0;
    tag_exp = '0;
  endtask

  // One full session starting in IDLE; end_at = RUN beat carrying core_end_i (0 = never).
  task automatic session(input logic [1:0] req, input int end_at, input logic [31:0] cv_mask,
                         input logic [127:0] tag_val, input bit spurious, input bit drop,
                         output int n_cv);
    int              owner;
    logic [1:0]      oh;
    logic            prev_cv;
    logic [63:0]     prev_cipher;
    bit              ended;
    n_cv = 0;
    for (int c = 0; c < 2; c++) begin
      bus.key_i[c]   = {$urandom(), $urandom(), $urandom(), $urandom()};
      bus.nonce_i[c] = {$urandom(), $urandom(), $urandom(), $urandom()};
    end
    bus.req_i               = req;
    bus.core_end_i          = spurious;
    bus.core_cipher_valid_i = spurious;
    bus.core_tag_i          = {$urandom(), $urandom(), $urandom(), $urandom()};
    bus.core_cipher_i       = {$urandom(), $urandom()};
    @(negedge clk);
    check_eq("idle_gnt", bus.gnt_o, '0);
    check_eq("idle_start", bus.core_start_o, 1'b0);
    owner = model_pick(req, prio);
    oh    = 2'(1 << owner);
    step();

    bus.core_end_i          = 1'b0;
    bus.core_cipher_valid_i = 1'b0;
    if (drop) bus.req_i[owner] = 1'b0;
    @(negedge clk);
    check_eq("start_gnt", bus.gnt_o, oh);
    check_eq("start_pulse", bus.core_start_o, 1'b1);
    check_eq("start_key", bus.core_key_o, bus.key_i[owner]);
    check_eq("start_nonce", bus.core_nonce_o, bus.nonce_i[owner]);
    check_eq("start_cdv", bus.core_data_valid_o, 1'b0);
    check_eq("start_cv", bus.cipher_valid_o, '0);
    check_eq("start_tag", bus.tag_o, tag_exp);
    step();

    prev_cv     = 1'b0;
    prev_cipher = '0;
    ended       = 1'b0;
    for (int k = 1; k <= int'(T); k++) begin
      bus.data_i[0]           = {$urandom(), $urandom()};
      bus.data_i[1]           = {$urandom(), $urandom()};
      bus.data_valid_i        = 2'($urandom_range(0, 3));
      bus.core_cipher_valid_i = cv_mask[k-1];
      bus.core_cipher_i       = {$urandom(), $urandom()};
      bus.core_end_i          = (k == end_at);
      bus.core_tag_i          = (k == end_at) ? tag_val
                                : {$urandom(), $urandom(), $urandom(), $urandom()};
      @(negedge clk);
      check_eq("run_gnt", bus.gnt_o, oh);
      check_eq("run_start", bus.core_start_o, 1'b0);
      check_eq("run_cdata", bus.core_data_o, bus.data_i[owner]);
      check_eq("run_cdv", bus.core_data_valid_o, bus.data_valid_i[owner]);
      check_eq("run_key", bus.core_key_o, bus.key_i[owner]);
      check_eq("run_cv", bus.cipher_valid_o, prev_cv ? oh : 2'b00);
      if (prev_cv) check_eq("run_cipher", bus.cipher_o, prev_cipher);
      check_eq("run_done", bus.done_o, '0);
      check_eq("run_err", bus.err_o, '0);
      if (bus.cipher_valid_o != '0) n_cv++;
      prev_cv     = cv_mask[k-1];
      prev_cipher = bus.core_cipher_i;
      if (k == end_at) begin
        ended   = 1'b1;
        tag_exp = tag_val;
      end
      step();
      if (ended) break;
    end

    bus.core_cipher_valid_i = 1'b0;
    bus.core_end_i          = 1'($urandom_range(0, 1));
    bus.data_valid_i        = 2'b11;
    @(negedge clk);
    check_eq("end_done", bus.done_o, ended ? oh : 2'b00);
    check_eq("end_err", bus.err_o, ended ? 2'b00 : oh);
    check_eq("end_gnt", bus.gnt_o, oh);
    check_eq("end_start", bus.core_start_o, 1'b0);
    check_eq("end_cdv", bus.core_data_valid_o, 1'b0);
    check_eq("end_ckey", bus.core_key_o, '0);
    check_eq("end_tag", bus.tag_o, tag_exp);
    check_eq("end_cv", bus.cipher_valid_o, prev_cv ? oh : 2'b00);
    if (prev_cv) check_eq("end_cipher", bus.cipher_o, prev_cipher);
    if (bus.cipher_valid_o != '0) n_cv++;
    prio = 1 - owner;
    step();

    bus.req_i        = '0;
    bus.core_end_i   = 1'b0;
    bus.data_valid_i = '0;
    @(negedge clk);
    check_eq("post_gnt", bus.gnt_o, '0);
    check_eq("post_done", bus.done_o, '0);
    check_eq("post_err", bus.err_o, '0);
    check_eq("post_cv", bus.cipher_valid_o, '0);
    check_eq("post_tag", bus.tag_o, tag_exp);
    step();
  endtask

  initial begin
    int n_cv;
    rst = 1'b1;
    apply_reset();

    // Single request with four cipher beats and an A5 tag.
    session(2'b01, 5, 32'h0000_000F, {16{8'hA5}}, 1'b0, 1'b0, n_cv);
    check_eq("single_cv_count", n_cv, 4);

    // Contention from reset: 0, then 1, then 0 again.
    apply_reset();
    session(2'b11, 3, $urandom(), {$urandom(), $urandom(), $urandom(), $urandom()}, 0, 0, n_cv);
    session(2'b11, 2, $urandom(), {$urandom(), $urandom(), $urandom(), $urandom()}, 0, 0, n_cv);
    session(2'b11, 4, $urandom(), {$urandom(), $urandom(), $urandom(), $urandom()}, 0, 0, n_cv);

    // Timeout, then end coinciding with expiry, then spurious core strobes in IDLE.
    session(2'b01, 0, $urandom(), '0, 1'b0, 1'b0, n_cv);
    session(2'b10, int'(T), $urandom(), {4{32'h1234_5678}}, 1'b0, 1'b1, n_cv);
    session(2'b01, 6, $urandom(), {4{32'h0BAD_CAFE}}, 1'b1, 1'b0, n_cv);

    // Reset during RUN abandons the session silently.
    bus.req_i = 2'b01;
    step();
    step();
    bus.core_cipher_valid_i = 1'b1;
    bus.data_valid_i        = 2'b01;
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("midrun_reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_inputs();
    prio    = 0;
    tag_exp = '0;
    @(negedge clk);
    check_eq("after_reset_gnt", bus.gnt_o, '0);
    check_eq("after_reset_done", bus.done_o, '0);
    check_eq("after_reset_err", bus.err_o, '0);
    step();
    session(2'b10, 2, $urandom(), {4{32'hFEED_F00D}}, 1'b0, 1'b0, n_cv);

    for (int i = 0; i < 30; i++) begin
      session(2'($urandom_range(1, 3)), $urandom_range(0, T), $urandom(),
              {$urandom(), $urandom(), $urandom(), $urandom()},
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), n_cv);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ascon_session_arbiter.md
ASCON_SESSION_ARBITER -- requirements
Module: ascon_session_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clock_i, resetb_i (resetb_i = 1 resets).
REQ-002 Parameter TIMEOUT_CYCLES, default 1023, SHALL set the maximum cycles from start_o to core end_i before the session aborts.
REQ-003 Ports SHALL be:
- clock_i  in  1  system clock
- resetb_i  in  1  asynchronous reset, active-high
- req_i  in  2  per-client session request, level, held until done
- key_i  in  2x128  per-client key, stable while req_i is high
- nonce_i  in  2x128  per-client nonce, stable while req_i is high
- data_i  in  2x64  per-client data block
- data_valid_i  in  2  per-client data strobe
- gnt_o  out  2  one-hot current owner
- done_o  out  2  one-cycle session-complete pulse to owner
- err_o  out  2  one-cycle timeout pulse to owner
- cipher_o  out  64  registered cipher block returned to owner
- cipher_valid_o  out  2  one-cycle cipher strobe to owner
- tag_o  out  128  registered tag, held until the next session completes
- core_start_o  out  1  core start pulse
- core_key_o  out  128  owner key to core
- core_nonce_o  out  128  owner nonce to core
- core_data_o  out  64  owner data to core
- core_data_valid_o  out  1  owner data strobe to core
- core_cipher_i  in  64  core cipher block
- core_cipher_valid_i  in  1  core cipher strobe
- core_tag_i  in  128  core tag
- core_end_i  in  1  core end-of-session pulse

Function
REQ-004 FSM states SHALL be IDLE, START, RUN, DONE and ABORT.
REQ-005 IDLE: when any req_i bit is high, the block SHALL latch the owner and go to START on the next edge. Both bits high SHALL grant the client other than the last owner; the priority pointer SHALL reset to client 0 first.
REQ-006 START: the block SHALL drive core_start_o=1 for exactly one cycle with core_key_o/core_nonce_o muxed from the owner, load the watchdog with TIMEOUT_CYCLES, then go to RUN.
REQ-007 gnt_o SHALL be one-hot to the owner in START, RUN, DONE and ABORT, and 0 in IDLE.
REQ-008 RUN: core_data_o/core_data_valid_o SHALL combinationally follow the owner's data_i/data_valid_i. The non-owner's data_valid_i SHALL be ignored.
REQ-009 RUN: on core_cipher_valid_i, the block SHALL register core_cipher_i into cipher_o and pulse cipher_valid_o[owner] on the following cycle (latency 1).
REQ-010 RUN: on core_end_i, the block SHALL register core_tag_i into tag_o and go to DONE. In DONE it SHALL pulse done_o[owner] for one cycle, toggle the priority pointer, and return to IDLE.
REQ-011 The watchdog SHALL decrement each RUN cycle. When it reaches 0 without core_end_i, the block SHALL go to ABORT, pulse err_o[owner] for one cycle, leave tag_o unchanged, toggle the priority pointer, and return to IDLE.
REQ-012 core_end_i and watchdog expiry in the same cycle SHALL be treated as normal completion.
REQ-013 The owner dropping req_i mid-session SHALL NOT end the session. The session SHALL complete or abort normally, and the client SHALL NOT be regranted until it re-asserts req_i in IDLE.
REQ-014 core_cipher_valid_i or core_end_i arriving outside RUN SHALL be ignored.
REQ-015 Core outputs SHALL be 0 whenever the FSM is not in START or RUN.

Reset
REQ-016 resetb_i SHALL asynchronously force the FSM to IDLE and the priority pointer to client 0. It SHALL force gnt_o, done_o, err_o, cipher_valid_o, cipher_o, tag_o, core_start_o and core_data_valid_o to 0.
REQ-017 Reset mid-session SHALL abandon the session with no done_o or err_o pulse.

Structure
REQ-018 The FSM state enum and the ASCON key/nonce/block width constants SHALL be declared in ascon_pack.
REQ-019 The watchdog SHALL be a sub-module, watchdog_cpt, providing load, enable and a zero flag.
REQ-020 Total RTL SHALL be within 120-400 lines.

Verification
REQ-021 The bench SHALL cover the following directed scenarios:
- Single request: req_i=01 → gnt_o=01 next cycle, core_start_o one pulse; 4 core_cipher_valid_i pulses → 4 cipher_valid_o=01 pulses; core_end_i with tag 0xA5..A5 → tag_o=0xA5..A5 and done_o=01 one cycle.
- Contention: req_i=11 from reset → client 0 served first, then client 1; next contention with req_i=11 → client 0 again.
- Timeout: TIMEOUT_CYCLES=8, no core_end_i → err_o one-cycle pulse exactly 8 RUN cycles after START, tag_o unchanged, FSM back in IDLE.
- Isolation: client 1 strobes data_valid_i while client 0 owns → core_data_valid_o follows client 0 only; spurious core_end_i in IDLE → no effect.
- Reset: resetb_i pulsed in RUN → all outputs 0 asynchronously, no done_o or err_o; next req_i=10 → client 1 granted normally.
